// File: rtl/gdo_pkg.sv
// gdo datapath arithmetic: wrapping two's-complement integer add/multiply on a wide raw word.
// Callers size operands up to gdo_raw_t and truncate results back to their own word width.
package gdo;

    localparam int GDO_MAX_W = 64;

    typedef logic [GDO_MAX_W-1:0] gdo_raw_t;

    function automatic gdo_raw_t gdo_add(input gdo_raw_t a, input gdo_raw_t b);
        return a + b;
    endfunction

    function automatic gdo_raw_t gdo_mult(input gdo_raw_t a, input gdo_raw_t b);
        return a * b;
    endfunction

endpackage

// File: rtl/systolic_pkg.sv
// Shared types for the weight-stationary systolic array: sequencer states, valid-pipe beat, latency.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} sa_state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } beat_t;

    // Edges from input acceptance to the aligned result appearing on the output.
    function automatic int latency(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Weight-stationary MAC cell: holds one weight, passes activations right and partial sums down.
module systolic_pe
    import gdo::*;
#(
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 w_load,
    input  logic [DATA_SIZE-1:0] w_in,
    input  logic [DATA_SIZE-1:0] a_in,
    input  logic [DATA_SIZE-1:0] s_in,
    output logic [DATA_SIZE-1:0] a_out,
    output logic [DATA_SIZE-1:0] s_out
);

    typedef logic [DATA_SIZE-1:0] word_t;

    word_t w_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else if (w_load) begin
            w_q <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            s_out <= '0;
        end else if (en) begin
            a_out <= a_in;
            s_out <= DATA_SIZE'(gdo_add(gdo_raw_t'(s_in),
                                        gdo_mult(gdo_raw_t'(a_in), gdo_raw_t'(w_q))));
        end
    end

endmodule

// File: rtl/systolic_stream_array.sv
// ROWS x COLS weight-stationary systolic array computing y[n] = sum_k x[k]*w[k][n] on streamed vectors,
// with input skew, output deskew, a {valid,last} shadow pipe and a load/stream/drain sequencer.
module systolic_stream_array
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [DATA_SIZE*COLS-1:0] w_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_SIZE*ROWS-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_SIZE*COLS-1:0] out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int LATENCY = latency(ROWS, COLS);
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef logic [DATA_SIZE-1:0] word_t;

    sa_state_t      state, state_next;
    logic [RW-1:0]  w_row;
    logic           stall, en, accept, w_accept, pending;
    beat_t          in_beat;
    beat_t          vpipe [LATENCY];
    word_t          x_reg [ROWS];
    word_t          a_h [ROWS][COLS];
    word_t          a_unused [ROWS];
    word_t          s_v [ROWS+1][COLS];
    word_t          col_out [COLS];
    word_t          out_q [COLS];

    assign out_valid = vpipe[LATENCY-1].valid;
    assign out_last  = vpipe[LATENCY-1].last;
    assign stall     = out_valid & ~out_ready;
    assign en        = ~stall;
    assign busy      = (state != IDLE);
    assign w_ready   = (state == IDLE) || (state == LOAD_W);
    assign in_ready  = (state == STREAM) && !stall;
    assign accept    = in_valid & in_ready;
    assign w_accept  = w_valid & w_ready;

    // Anything still in flight other than the result sitting on the output.
    always_comb begin
        pending = in_beat.valid;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending = pending | vpipe[i].valid;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (w_valid)       state_next = (ROWS == 1) ? STREAM : LOAD_W;
                else if (in_valid) state_next = STREAM;
            end
            LOAD_W:  if (w_valid && w_row == RW'(ROWS - 1)) state_next = STREAM;
            STREAM:  if (accept && in_last) state_next = DRAIN;
            DRAIN:   if (!pending && (!out_valid || out_ready)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w_row <= '0;
        end else begin
            state <= state_next;
            if (w_accept) w_row <= (w_row == RW'(ROWS - 1)) ? '0 : w_row + 1'b1;
        end
    end

    // NOTE: these register arrays are pipeline state, not RAM, so they are cleared by reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_beat <= '0;
            for (int i = 0; i < LATENCY; i++) vpipe[i] <= '0;
            for (int r = 0; r < ROWS; r++) x_reg[r] <= '0;
            for (int c = 0; c < COLS; c++) out_q[c] <= '0;
        end else if (en) begin
            in_beat  <= '{valid: accept, last: accept & in_last};
            vpipe[0] <= in_beat;
            for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
            for (int r = 0; r < ROWS; r++) x_reg[r] <= in_data[DATA_SIZE*(ROWS-r)-1 -: DATA_SIZE];
            for (int c = 0; c < COLS; c++) out_q[c] <= col_out[c];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        if (r == 0) begin : g_noskew
            assign a_h[r][0] = x_reg[r];
        end else begin : g_skew
            word_t sk [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) sk[i] <= '0;
                end else if (en) begin
                    sk[0] <= x_reg[r];
                    for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
                end
            end
            assign a_h[r][0] = sk[r-1];
        end

        for (genvar c = 0; c < COLS; c++) begin : g_col
            word_t a_nxt;
            systolic_pe #(.DATA_SIZE(DATA_SIZE)) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (en),
                .w_load (w_accept && (w_row == RW'(r))),
                .w_in   (w_data[DATA_SIZE*(COLS-c)-1 -: DATA_SIZE]),
                .a_in   (a_h[r][c]),
                .s_in   (s_v[r][c]),
                .a_out  (a_nxt),
                .s_out  (s_v[r+1][c])
            );
            if (c < COLS - 1) begin : g_pass
                assign a_h[r][c+1] = a_nxt;
            end else begin : g_edge
                assign a_unused[r] = a_nxt;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_out
        localparam int D = COLS - 1 - c;
        assign s_v[0][c] = '0;
        if (D == 0) begin : g_nodeskew
            assign col_out[c] = s_v[ROWS][c];
        end else begin : g_deskew
            word_t dq [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) dq[i] <= '0;
                end else if (en) begin
                    dq[0] <= s_v[ROWS][c];
                    for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
                end
            end
            assign col_out[c] = dq[D-1];
        end
        assign out_data[DATA_SIZE*(COLS-c)-1 -: DATA_SIZE] = out_q[c];
    end

endmodule

// File: tb/tb_systolic_stream_array.sv
// Self-checking bench: random vector streams against a dot-product reference model with a result queue.
module tb_systolic_stream_array;

    localparam int DW   = 16;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LAT  = ROWS + COLS;
    localparam int XW   = DW * ROWS;
    localparam int YW   = DW * COLS;

    logic          clk;
    logic          rst_n;
    logic          w_valid;
    logic          w_ready;
    logic [YW-1:0] w_data;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] out_data;
    logic          out_last;
    logic          busy;

    systolic_stream_array #(.DATA_SIZE(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [YW-1:0] y;
        logic          last;
        int            acc;
    } exp_t;

    logic [DW-1:0] mw   [ROWS][COLS];
    logic [DW-1:0] wset [ROWS][COLS];
    exp_t          exp_q [$];
    int            pop_cyc [$];
    int            mrow = 0;
    bit            head_seen = 0;
    int            head_first = 0;
    int            last_lat = 0;
    logic [YW-1:0] last_y = '0;
    logic          last_last = 1'b0;
    int            or_mode = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Expected result: plain dot products with the weights the model has seen loaded, modulo 2^DW.
    function automatic logic [YW-1:0] model_y(input logic [XW-1:0] x);
        logic [YW-1:0] y;
        int unsigned   acc;
        logic [DW-1:0] xk;
        y = '0;
        for (int n = 0; n < COLS; n++) begin
            acc = 0;
            for (int k = 0; k < ROWS; k++) begin
                xk  = x[DW*(ROWS-k)-1 -: DW];
                acc = acc + 32'(xk) * 32'(mw[k][n]);
            end
            y[DW*(COLS-n)-1 -: DW] = acc[DW-1:0];
        end
        return y;
    endfunction

    // Compare process: observes handshakes just before the edge they complete on.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            mrow      = 0;
            head_seen = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) mw[r][c] = '0;
        end else begin
            if (w_valid && w_ready) begin
                for (int c = 0; c < COLS; c++) mw[mrow][c] = w_data[DW*(COLS-c)-1 -: DW];
                mrow = (mrow + 1) % ROWS;
            end
            if (in_valid && in_ready) begin
                e.y    = model_y(in_data);
                e.last = in_last;
                e.acc  = cyc + 1;
                exp_q.push_back(e);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_data, '0);
                end else begin
                    if (!head_seen) begin
                        head_seen  = 1;
                        head_first = cyc;
                    end
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.y);
                        check("out_last", YW'(out_last), YW'(e.last));
                        last_lat  = head_first - e.acc;
                        last_y    = out_data;
                        last_last = out_last;
                        pop_cyc.push_back(cyc);
                        head_seen = 0;
                    end else begin
                        check("in_ready_stall", YW'(in_ready), YW'(0));
                    end
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc / 3) % 2) == 0;
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic set_diag(input int scale);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wset[r][c] = (r == c) ? DW'(scale) : '0;
    endtask

    task automatic set_ones();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wset[r][c] = 1;
    endtask

    task automatic load_weights();
        bit ok;
        for (int r = 0; r < ROWS; r++) begin
            w_valid = 1'b1;
            for (int c = 0; c < COLS; c++) w_data[DW*(COLS-c)-1 -: DW] = wset[r][c];
            ok = 0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge clk);
                ok = w_ready;
                @(posedge clk);
                #1;
            end
            check("w_handshake", YW'(ok), YW'(1));
        end
        w_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [XW-1:0] x, input bit last);
        bit ok;
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_handshake", YW'(ok), YW'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = !busy && (exp_q.size() == 0);
            @(posedge clk);
            #1;
        end
        check("reach_idle", YW'(ok), YW'(1));
    endtask

    function automatic logic [XW-1:0] rand_vec();
        return {$urandom(), $urandom()};
    endfunction

    logic [XW-1:0] vec [16];
    logic [XW-1:0] x1, x2, x3;
    int            p0;

    initial begin
        rst_n    = 1'b0;
        w_valid  = 1'b0;
        w_data   = '0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        x1 = 64'h0001_0002_0003_0004;
        x2 = 64'h0005_0006_0007_0008;
        x3 = 64'h0010_0020_0030_0040;
        repeat (3) @(posedge clk);
        #1;
        check("rst_w_ready",   YW'(w_ready),   YW'(1));
        check("rst_in_ready",  YW'(in_ready),  YW'(0));
        check("rst_out_valid", YW'(out_valid), YW'(0));
        check("rst_out_last",  YW'(out_last),  YW'(0));
        check("rst_busy",      YW'(busy),      YW'(0));
        check("rst_out_data",  out_data,       '0);
        rst_n = 1'b1;

        // Identity weights, single vector batch: latency and value.
        set_diag(1);
        load_weights();
        check("stream_after_load", YW'(in_ready), YW'(1));
        check("model_identity", model_y(x1), x1);
        send_vec(x1, 1'b1);
        wait_idle();
        check("latency", YW'(last_lat), YW'(8));
        check("t1_y", last_y, 64'h0001_0002_0003_0004);
        check("t1_last", YW'(last_last), YW'(1));

        // All-ones weights, 16 back-to-back vectors.
        set_ones();
        load_weights();
        check("model_ones", model_y(x1), 64'h000A_000A_000A_000A);
        vec[0] = x1;
        for (int i = 1; i < 16; i++) vec[i] = rand_vec();
        p0 = pop_cyc.size();
        for (int i = 0; i < 16; i++) send_vec(vec[i], i == 15);
        wait_idle();
        check("t2_count", YW'(pop_cyc.size() - p0), YW'(16));
        check("t2_throughput", YW'(pop_cyc[p0+15] - pop_cyc[p0]), YW'(15));

        // Same stream with back-pressure, weights reused from IDLE.
        or_mode = 1;
        p0 = pop_cyc.size();
        for (int i = 0; i < 16; i++) send_vec(vec[i], i == 15);
        wait_idle();
        or_mode = 0;
        check("t3_count", YW'(pop_cyc.size() - p0), YW'(16));

        // Batch A identity, reload 2*identity, batch B.
        set_diag(1);
        load_weights();
        for (int i = 0; i < 3; i++) send_vec(rand_vec(), 1'b0);
        send_vec(x1, 1'b1);
        wait_idle();
        check("t4_a_unscaled", last_y, 64'h0001_0002_0003_0004);
        set_diag(2);
        load_weights();
        check("model_double", model_y(x2), 64'h000A_000C_000E_0010);
        for (int i = 0; i < 3; i++) send_vec(rand_vec(), 1'b0);
        send_vec(x2, 1'b1);
        wait_idle();
        check("t4_b_doubled", last_y, 64'h000A_000C_000E_0010);

        // Weight beats offered during STREAM are refused.
        send_vec(rand_vec(), 1'b0);
        w_valid = 1'b1;
        w_data  = '1;
        send_vec(rand_vec(), 1'b0);
        check("w_ready_in_stream", YW'(w_ready), YW'(0));
        send_vec(rand_vec(), 1'b0);
        w_valid = 1'b0;
        send_vec(x1, 1'b1);
        wait_idle();
        check("t5_weights_kept", last_y, 64'h0002_0004_0006_0008);

        // Batch of one straight from IDLE.
        p0 = pop_cyc.size();
        send_vec(x3, 1'b1);
        wait_idle();
        check("t5_single_count", YW'(pop_cyc.size() - p0), YW'(1));
        check("t5_single_y", last_y, 64'h0020_0040_0060_0080);

        // Reset while draining with results held by back-pressure.
        or_mode = 2;
        for (int i = 0; i < 3; i++) send_vec(rand_vec(), i == 2);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("t6_held_valid", YW'(out_valid), YW'(1));
        check("t6_held_busy",  YW'(busy),      YW'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", YW'(out_valid), YW'(0));
        check("t6_rst_busy",      YW'(busy),      YW'(0));
        check("t6_rst_w_ready",   YW'(w_ready),   YW'(1));
        check("t6_rst_out_data",  out_data,       '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        or_mode = 0;
        set_diag(1);
        load_weights();
        p0 = pop_cyc.size();
        for (int i = 0; i < 3; i++) send_vec(rand_vec(), 1'b0);
        send_vec(x2, 1'b1);
        wait_idle();
        check("t6_count", YW'(pop_cyc.size() - p0), YW'(4));
        check("t6_y", last_y, 64'h0005_0006_0007_0008);

        check("leftover", YW'(exp_q.size()), YW'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
